one_to_two_st_demux: RTL

Packet-aware 1:2 AXI4-Stream demultiplexer that steers one slave stream to one of two master streams, A or B. It samples `sel` on the first beat of each packet and holds that route until the `tlast` beat is accepted. Each output has a registered stage, so full throughput is kept while a stalled inactive output drains on its own. The block sits downstream of the stream sources as the distribution counterpart to the 2:1 stream mux, and returns traffic to one of two consumers.

---
 rtl/one_to_two_st_demux.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/one_to_two_st_demux.sv
// Packet-aware 1:2 AXI4-Stream demultiplexer.
// The route is sampled from `sel` on the first beat of a packet and held until
// the tlast beat is accepted. Each output owns a single registered stage, so an
// idle output can drain under its own tready without blocking the active one.

// Protocol checker: output hold rules and a known `sel` at packet start.
module one_to_two_st_demux_chk #(
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  is_idle,
    input logic                  sel,
    input logic                  s_axis_tvalid,
    input logic                  valid_a,
    input logic                  ready_a,
    input logic [DATA_WIDTH-1:0] data_a,
    input logic                  last_a,
    input logic                  valid_b,
    input logic                  ready_b,
    input logic [DATA_WIDTH-1:0] data_b,
    input logic                  last_b
);

    // A stalled output A must keep its beat unchanged until it is taken.
    a_hold_a : assert property (@(posedge clk) disable iff (!reset)
        (valid_a && !ready_a) |=> (valid_a && $stable(data_a) && $stable(last_a)))
        else $error("output A changed while stalled");

    // A stalled output B must keep its beat unchanged until it is taken.
    a_hold_b : assert property (@(posedge clk) disable iff (!reset)
        (valid_b && !ready_b) |=> (valid_b && $stable(data_b) && $stable(last_b)))
        else $error("output B changed while stalled");

    // The route of a new packet is undefined if sel is not a known value.
    a_sel_known : assert property (@(posedge clk) disable iff (!reset)
        (is_idle && s_axis_tvalid) |-> !$isunknown(sel))
        else $error("sel unknown at packet start");

endmodule

module one_to_two_st_demux #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_A,
    output logic                  m_axis_tvalid_A,
    input  logic                  m_axis_tready_A,
    output logic                  m_axis_tlast_A,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_B,
    output logic                  m_axis_tvalid_B,
    input  logic                  m_axis_tready_B,
    output logic                  m_axis_tlast_B,
    output logic [CNT_WIDTH-1:0]  pkt_count_A,
    output logic [CNT_WIDTH-1:0]  pkt_count_B
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_r;
    logic                  route_r;

    logic                  va_r;
    logic                  la_r;
    logic [DATA_WIDTH-1:0] da_r;
    logic                  vb_r;
    logic                  lb_r;
    logic [DATA_WIDTH-1:0] db_r;

    logic [CNT_WIDTH-1:0]  cnt_a_r;
    logic [CNT_WIDTH-1:0]  cnt_b_r;

    logic                  eff_s;
    logic                  rdy_a_s;
    logic                  rdy_b_s;
    logic                  acc_s;
    logic                  load_a_s;
    logic                  load_b_s;

    // Effective route and input handshake; sel reaches tready directly while idle.
    always_comb begin
        eff_s         = (state_r == ST_IDLE) ? sel : route_r;
        rdy_a_s       = ~va_r | m_axis_tready_A;
        rdy_b_s       = ~vb_r | m_axis_tready_B;
        s_axis_tready = eff_s ? rdy_b_s : rdy_a_s;
        acc_s         = s_axis_tvalid & s_axis_tready;
        load_a_s      = acc_s & ~eff_s;
        load_b_s      = acc_s & eff_s;
    end

    // Packet framing FSM: lock the route on a multi-beat packet start, release on tlast.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            route_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s && !s_axis_tlast) begin
                        state_r <= ST_LOCKED;
                        route_r <= sel;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (acc_s && s_axis_tlast) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    route_r <= 1'b0;
                end
            endcase
        end
    end

    // Output stage A: a load wins over a drain so back-to-back beats stay valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            va_r <= 1'b0;
            la_r <= 1'b0;
            da_r <= {DATA_WIDTH{1'b0}};
        end else if (load_a_s) begin
            va_r <= 1'b1;
            la_r <= s_axis_tlast;
            da_r <= s_axis_tdata;
        end else if (va_r && m_axis_tready_A) begin
            va_r <= 1'b0;
        end else begin
            va_r <= va_r;
        end
    end

    // Output stage B: same behaviour as stage A, driven by its own tready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vb_r <= 1'b0;
            lb_r <= 1'b0;
            db_r <= {DATA_WIDTH{1'b0}};
        end else if (load_b_s) begin
            vb_r <= 1'b1;
            lb_r <= s_axis_tlast;
            db_r <= s_axis_tdata;
        end else if (vb_r && m_axis_tready_B) begin
            vb_r <= 1'b0;
        end else begin
            vb_r <= vb_r;
        end
    end

    // Packet counters: bump when a tlast beat enters a stage; wrap on overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_a_r <= {CNT_WIDTH{1'b0}};
            cnt_b_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (load_a_s && s_axis_tlast) begin
                cnt_a_r <= cnt_a_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (load_b_s && s_axis_tlast) begin
                cnt_b_r <= cnt_b_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign m_axis_tvalid_A = va_r;
    assign m_axis_tlast_A  = la_r;
    assign m_axis_tdata_A  = da_r;
    assign m_axis_tvalid_B = vb_r;
    assign m_axis_tlast_B  = lb_r;
    assign m_axis_tdata_B  = db_r;
    assign pkt_count_A     = cnt_a_r;
    assign pkt_count_B     = cnt_b_r;

    one_to_two_st_demux_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .is_idle       (state_r == ST_IDLE),
        .sel           (sel),
        .s_axis_tvalid (s_axis_tvalid),
        .valid_a       (va_r),
        .ready_a       (m_axis_tready_A),
        .data_a        (da_r),
        .last_a        (la_r),
        .valid_b       (vb_r),
        .ready_b       (m_axis_tready_B),
        .data_b        (db_r),
        .last_b        (lb_r)
    );

endmodule
